// File: rtl/ex_alu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ex_alu_unit
//  Description : Execute-stage ALU with a valid/ready handshake on both
//                sides. Logic ops, add/sub and slt complete in one cycle.
//                Shifts are performed iteratively, one bit per cycle, and
//                stall the upstream stage through in_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_alu_unit #(
  parameter int WIDTH = 32  // shift amount is b[4:0], so WIDTH must be >= 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       rd_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [4:0]       rd_out
);

  localparam logic [3:0] c_op_and = 4'b0000;
  localparam logic [3:0] c_op_or  = 4'b0001;
  localparam logic [3:0] c_op_add = 4'b0010;
  localparam logic [3:0] c_op_sll = 4'b0011;
  localparam logic [3:0] c_op_srl = 4'b0100;
  localparam logic [3:0] c_op_sra = 4'b0101;
  localparam logic [3:0] c_op_sub = 4'b0110;
  localparam logic [3:0] c_op_slt = 4'b0111;
  localparam logic [3:0] c_op_xor = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [4:0]       rd_q, rd_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;

  logic             w_accept;
  logic             w_is_shift;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_sh_next;
  logic [WIDTH-1:0] w_fast_res;

  // Upstream may hand over a new op when idle, or when the held result
  // leaves on this same edge; never while shifting or under reset.
  assign in_ready = ~reset & ((state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready));
  assign w_accept = in_valid & in_ready;

  assign w_is_shift = (aluctl == c_op_sll) | (aluctl == c_op_srl) | (aluctl == c_op_sra);

  // Single-cycle datapath; unknown codes produce zero.
  always_comb begin
    w_alu = '0;
    case (aluctl)
      c_op_and: w_alu = a & b;
      c_op_or:  w_alu = a | b;
      c_op_add: w_alu = a + b;
      c_op_sub: w_alu = a - b;
      c_op_xor: w_alu = a ^ b;
      c_op_slt: w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default:  w_alu = '0;
    endcase
  end

  // A shift by zero is just a pass-through of operand A.
  assign w_fast_res = w_is_shift ? a : w_alu;

  // One-bit shift step applied to the working register each SHIFT cycle.
  always_comb begin
    w_sh_next = sh_q;
    case (op_q)
      c_op_sll: w_sh_next = {sh_q[WIDTH-2:0], 1'b0};
      c_op_srl: w_sh_next = {1'b0, sh_q[WIDTH-1:1]};
      c_op_sra: w_sh_next = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
      default:  w_sh_next = sh_q;
    endcase
  end

  // Next-state and datapath update; a new accept overrides the state's own
  // transition so a transfer and an accept can share one edge.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    rd_d     = rd_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    op_d     = op_q;

    case (state_q)
      S_SHIFT: begin
        sh_d  = w_sh_next;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          result_d = w_sh_next;
          zero_d   = (w_sh_next == '0);
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = state_q;
    endcase

    if (w_accept) begin
      rd_d = rd_in;
      if (w_is_shift && (b[4:0] != 5'd0)) begin
        sh_d    = a;
        cnt_d   = b[4:0];
        op_d    = aluctl;
        state_d = S_SHIFT;
      end else begin
        result_d = w_fast_res;
        zero_d   = (w_fast_res == '0);
        state_d  = S_HOLD;
      end
    end
  end

  // State register with synchronous reset that discards any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      rd_q     <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      rd_q     <= rd_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
    end
  end

  assign out_valid = (state_q == S_HOLD);
  assign result    = result_q;
  assign zero      = zero_q;
  assign rd_out    = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_alu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_alu_unit
//  Description : Self-checking scoreboard bench for ex_alu_unit using
//                directed vectors with hand-computed expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_alu_unit;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       aluctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       rd_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [4:0]       rd_out;

  ex_alu_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluctl    (aluctl),
    .a         (a),
    .b         (b),
    .rd_in     (rd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .rd_out    (rd_out)
  );

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic [4:0]  rd;
    int          due;
    bit          exact;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compares every output transfer against the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_output: got result %h rd %0d with nothing pending", result, rd_out);
      end else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("zero", {31'd0, zero}, {31'd0, e.z});
        check("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
        if (e.exact) check("latency", cyc, e.due);
        else         check("latency_min", {31'd0, (cyc >= e.due)}, 32'd1);
      end
    end
  end

  // Present one op, wait for acceptance, record its expectation.
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                       input logic [4:0] rd, input logic [31:0] exp_res, input int n,
                       input bit exact, input bit push);
    int   waited;
    exp_t e;
    in_valid = 1'b1;
    aluctl   = op;
    a        = va;
    b        = vb;
    rd_in    = rd;
    #1;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (in_ready !== 1'b1) begin
      total++;
      $display("FAIL accept_timeout: op %b never accepted, in_ready %b expected 1", op, in_ready);
    end else if (push) begin
      e.res   = exp_res;
      e.z     = (exp_res == 32'd0);
      e.rd    = rd;
      e.due   = cyc + 1 + n;
      e.exact = exact;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, sb.size(), 32'd0);
  endtask

  initial begin : stim
    int  n;
    bit  stale;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    aluctl    = 4'd0;
    a         = '0;
    b         = '0;
    rd_in     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_rd_out", {27'd0, rd_out}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // ADD, then out_valid must drop after a single cycle
    issue(4'b0010, 32'd5, 32'd7, 5'd3, 32'd12, 0, 1, 1);
    @(posedge clk); #1;
    check("add_valid_one_cycle", {31'd0, out_valid}, 32'd0);

    // Arithmetic corner cases and an undefined code
    issue(4'b0110, 32'd9, 32'd9, 5'd4, 32'd0, 0, 1, 1);
    issue(4'b0110, 32'd0, 32'd1, 5'd5, 32'hFFFF_FFFF, 0, 1, 1);
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd6, 32'd1, 0, 1, 1);
    issue(4'b0111, 32'd1, 32'hFFFF_FFFF, 5'd7, 32'd0, 0, 1, 1);
    issue(4'b1111, 32'd3, 32'd4, 5'd8, 32'd0, 0, 1, 1);
    drain("drain_arith");

    // SRA by 4: in_ready low for 4 cycles, latency 5
    @(posedge clk); #1;
    issue(4'b0101, 32'h8000_0000, 32'd4, 5'd9, 32'hF800_0000, 4, 1, 1);
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    check("sra_stall_cycles", n, 32'd4);
    drain("drain_sra");

    // Shift by zero, shift amount taken from b[4:0], worst-case shift
    issue(4'b0011, 32'h1234_5678, 32'd0, 5'd10, 32'h1234_5678, 0, 1, 1);
    issue(4'b0011, 32'h0000_0003, 32'h0000_0024, 5'd11, 32'h0000_0030, 4, 1, 1);
    issue(4'b0100, 32'h8000_0000, 32'd31, 5'd12, 32'h0000_0001, 31, 1, 1);
    drain("drain_shifts");

    // Back-to-back single-cycle stream
    issue(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd13, 32'h00F0_00F0, 0, 1, 1);
    issue(4'b0001, 32'h00FF_0000, 32'h0000_FF00, 5'd14, 32'h00FF_FF00, 0, 1, 1);
    issue(4'b1100, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd15, 32'hF0F0_0F0F, 0, 1, 1);
    issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd16, 32'd0, 0, 1, 1);
    drain("drain_stream");

    // Backpressure: result held stable, inputs ignored, then transfer+accept
    out_ready = 1'b0;
    issue(4'b0010, 32'd100, 32'd23, 5'd17, 32'd123, 0, 0, 1);
    in_valid = 1'b1;
    aluctl   = 4'b0110;
    a        = 32'd50;
    b        = 32'd8;
    rd_in    = 5'd18;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_result", result, 32'd123);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(4'b0110, 32'd50, 32'd8, 5'd18, 32'd42, 0, 1, 1);
    drain("drain_hold");

    // Reset during the second cycle of an SLL by 10
    issue(4'b0011, 32'd1, 32'd10, 5'd19, 32'd1024, 10, 1, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("mid_reset_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("mid_reset_valid", {31'd0, out_valid}, 32'd0);
    check("mid_reset_result", result, 32'd0);
    reset = 1'b0;
    #1;
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    stale = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    check("no_stale_result", {31'd0, stale}, 32'd0);

    // Normal operation resumes after the reset
    issue(4'b0010, 32'd1, 32'd2, 5'd20, 32'd3, 0, 1, 1);
    drain("drain_final");
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
